// File: rtl/taxi_trip_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : taxi_trip_ctrl
// Description : Taximeter trip sequencer. Counts wheel pulses into whole
//               kilometres and stationary seconds into waiting minutes,
//               steps IDLE -> RUN -> BILL and latches the fare on alighting.
// Revision    : 1.0 - initial release
// ============================================================================
module taxi_trip_ctrl #(
    parameter int PULSES_PER_KM = 10,
    parameter int WAIT_SECS     = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic        wheel_pulse,
    input  logic        tick_1s,
    input  logic [10:0] cost_in,
    output logic [7:0]  mil,
    output logic [6:0]  timee,
    output logic [10:0] bill,
    output logic        bill_valid,
    output logic        busy,
    output logic [1:0]  state
);

    localparam int c_PW = $clog2(PULSES_PER_KM);
    localparam int c_SW = $clog2(WAIT_SECS);

    localparam logic [c_PW-1:0] c_PULSE_MAX = c_PW'(PULSES_PER_KM - 1);
    localparam logic [c_SW-1:0] c_SEC_MAX   = c_SW'(WAIT_SECS - 1);
    localparam logic [7:0]      c_MIL_SAT   = 8'd255;
    localparam logic [6:0]      c_TIME_SAT  = 7'd127;

    localparam logic [1:0] c_IDLE = 2'b00;
    localparam logic [1:0] c_RUN  = 2'b01;
    localparam logic [1:0] c_BILL = 2'b10;

    logic [1:0]      r_state,      w_state_nxt;
    logic [c_PW-1:0] r_pulse_cnt,  w_pulse_cnt_nxt;
    logic [c_SW-1:0] r_sec_cnt,    w_sec_cnt_nxt;
    logic            r_moved,      w_moved_nxt;
    logic [7:0]      r_mil,        w_mil_nxt;
    logic [6:0]      r_timee,      w_timee_nxt;
    logic [10:0]     r_bill,       w_bill_nxt;
    logic            r_bill_valid, w_bill_valid_nxt;
    logic            r_busy;

    // State and counter registers; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_pulse_cnt  <= '0;
            r_sec_cnt    <= '0;
            r_moved      <= 1'b0;
            r_mil        <= '0;
            r_timee      <= '0;
            r_bill       <= '0;
            r_bill_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pulse_cnt  <= w_pulse_cnt_nxt;
            r_sec_cnt    <= w_sec_cnt_nxt;
            r_moved      <= w_moved_nxt;
            r_mil        <= w_mil_nxt;
            r_timee      <= w_timee_nxt;
            r_bill       <= w_bill_nxt;
            r_bill_valid <= w_bill_valid_nxt;
            r_busy       <= (w_state_nxt == c_RUN);
        end
    end

    // Next-state, distance/waiting counting and bill capture.
    always_comb begin
        w_state_nxt      = r_state;
        w_pulse_cnt_nxt  = r_pulse_cnt;
        w_sec_cnt_nxt    = r_sec_cnt;
        w_moved_nxt      = r_moved;
        w_mil_nxt        = r_mil;
        w_timee_nxt      = r_timee;
        w_bill_nxt       = r_bill;
        w_bill_valid_nxt = r_bill_valid;

        case (r_state)
            c_IDLE: begin
                // Counters are already zero here, so start only moves state.
                if (start) begin
                    w_state_nxt = c_RUN;
                end
            end

            c_RUN: begin
                if (clear) begin
                    w_state_nxt     = c_IDLE;
                    w_pulse_cnt_nxt = '0;
                    w_sec_cnt_nxt   = '0;
                    w_moved_nxt     = 1'b0;
                    w_mil_nxt       = '0;
                    w_timee_nxt     = '0;
                end else if (stop) begin
                    // Sensor events in the stop cycle are dropped so the
                    // captured fare matches the displayed mil/timee.
                    w_state_nxt      = c_BILL;
                    w_bill_nxt       = cost_in;
                    w_bill_valid_nxt = 1'b1;
                end else begin
                    if (wheel_pulse) begin
                        if (r_pulse_cnt == c_PULSE_MAX) begin
                            w_pulse_cnt_nxt = '0;
                            if (r_mil != c_MIL_SAT) begin
                                w_mil_nxt = r_mil + 8'd1;
                            end
                        end else begin
                            w_pulse_cnt_nxt = r_pulse_cnt + c_PW'(1);
                        end
                    end
                    // A tick closes the one-second window: it counts only if
                    // the cab did not move during it, and starts a new window.
                    if (tick_1s) begin
                        w_moved_nxt = 1'b0;
                        if (!r_moved && !wheel_pulse) begin
                            if (r_sec_cnt == c_SEC_MAX) begin
                                w_sec_cnt_nxt = '0;
                                if (r_timee != c_TIME_SAT) begin
                                    w_timee_nxt = r_timee + 7'd1;
                                end
                            end else begin
                                w_sec_cnt_nxt = r_sec_cnt + c_SW'(1);
                            end
                        end
                    end else if (wheel_pulse) begin
                        w_moved_nxt = 1'b1;
                    end
                end
            end

            c_BILL: begin
                if (clear || start) begin
                    w_state_nxt      = clear ? c_IDLE : c_RUN;
                    w_pulse_cnt_nxt  = '0;
                    w_sec_cnt_nxt    = '0;
                    w_moved_nxt      = 1'b0;
                    w_mil_nxt        = '0;
                    w_timee_nxt      = '0;
                    w_bill_valid_nxt = 1'b0;
                end
            end

            default: begin
                w_state_nxt      = c_IDLE;
                w_pulse_cnt_nxt  = '0;
                w_sec_cnt_nxt    = '0;
                w_moved_nxt      = 1'b0;
                w_mil_nxt        = '0;
                w_timee_nxt      = '0;
                w_bill_valid_nxt = 1'b0;
            end
        endcase
    end

    assign mil        = r_mil;
    assign timee      = r_timee;
    assign bill       = r_bill;
    assign bill_valid = r_bill_valid;
    assign busy       = r_busy;
    assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_taxi_trip_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_taxi_trip_ctrl
// Description : Directed self-checking bench for taxi_trip_ctrl with a
//               small stand-in fare block driving cost_in.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_taxi_trip_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        clear = 1'b0;
    logic        wheel_pulse = 1'b0;
    logic        tick_1s = 1'b0;
    logic [10:0] cost_in;
    logic [7:0]  mil;
    logic [6:0]  timee;
    logic [10:0] bill;
    logic        bill_valid;
    logic        busy;
    logic [1:0]  state;

    int n_checks = 0;
    int n_fail   = 0;

    taxi_trip_ctrl #(
        .PULSES_PER_KM (10),
        .WAIT_SECS     (60)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .clear       (clear),
        .wheel_pulse (wheel_pulse),
        .tick_1s     (tick_1s),
        .cost_in     (cost_in),
        .mil         (mil),
        .timee       (timee),
        .bill        (bill),
        .bill_valid  (bill_valid),
        .busy        (busy),
        .state       (state)
    );

    always #5 clk = ~clk;

    // Stand-in fare block: 10 base covers 3 km, 1 per extra km, 1 per 4 waiting minutes.
    function automatic logic [10:0] fare(input logic [7:0] m, input logic [6:0] t);
        int c;
        c = 10 + ((m > 8'd3) ? (int'(m) - 3) : 0) + (int'(t) / 4);
        return 11'(c);
    endfunction

    assign cost_in = fare(mil, timee);

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; inputs are dropped 1 ns after the edge, where outputs are sampled.
    task automatic step(input logic s, input logic p, input logic t,
                        input logic st, input logic cl);
        start = st; stop = s; wheel_pulse = p; tick_1s = t; clear = cl;
        @(posedge clk);
        #1;
        start = 1'b0; stop = 1'b0; wheel_pulse = 1'b0; tick_1s = 1'b0; clear = 1'b0;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_state", state, 0);
        check("rst_mil", mil, 0);
        check("rst_timee", timee, 0);
        check("rst_bill", bill, 0);
        check("rst_bv", bill_valid, 0);
        check("rst_busy", busy, 0);

        // Trip 1: 53 pulses -> 5 km, remainder 3
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t1_state_run", state, 1);
        check("t1_busy", busy, 1);
        pulses(53);
        check("t1_mil", mil, 5);
        check("t1_pulse_cnt", dut.r_pulse_cnt, 3);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t1_state_bill", state, 2);
        check("t1_bill", bill, 12);
        check("t1_bv", bill_valid, 1);
        check("t1_busy_bill", busy, 0);

        // Sensors ignored in BILL; start+clear together -> IDLE
        pulses(10);
        ticks(5);
        check("bill_mil_hold", mil, 5);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("sc_state", state, 0);
        check("sc_mil", mil, 0);
        check("sc_timee", timee, 0);
        check("sc_bv", bill_valid, 0);
        check("sc_bill_hold", bill, 12);
        pulses(10);
        check("idle_mil", mil, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("idle_stop_state", state, 0);
        check("idle_stop_bv", bill_valid, 0);

        // Trip 2: 240 idle seconds -> 4 min, then 5 km
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        ticks(239);
        check("t2_timee_pre", timee, 3);
        ticks(1);
        check("t2_timee", timee, 4);
        pulses(50);
        check("t2_mil", mil, 5);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t2_bill", bill, 13);
        check("t2_state", state, 2);

        // start from BILL -> RUN with zeroed counters
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("br_state", state, 1);
        check("br_mil", mil, 0);
        check("br_timee", timee, 0);
        check("br_bv", bill_valid, 0);

        // Trip 3: coincident pulse+tick never counts as waiting
        for (int i = 0; i < 120; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("t3_timee_coinc", timee, 0);
        check("t3_mil", mil, 12);
        ticks(60);
        check("t3_timee_plain", timee, 1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("run_start_ign", mil, 12);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("stopclr_state", state, 0);
        check("stopclr_bill", bill, 13);
        check("stopclr_bv", bill_valid, 0);
        check("stopclr_mil", mil, 0);

        // Trip 4: saturation
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        pulses(2540);
        check("t4_mil_254", mil, 254);
        pulses(23460);
        check("t4_mil_sat", mil, 255);
        ticks(7800);
        check("t4_timee_sat", timee, 127);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t4_clear_state", state, 0);

        // Trip 6: reset mid-RUN at 7 km / 2 min (first tick after moving is discarded)
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        pulses(70);
        ticks(121);
        check("t6_mil", mil, 7);
        check("t6_timee", timee, 2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t6_rst_state", state, 0);
        check("t6_rst_mil", mil, 0);
        check("t6_rst_timee", timee, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_bill", bill, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t6_idle_stop", state, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
